// File: rtl/aes_pkg.sv
// Shared AES front-end definitions: key-size modes, block size and loader states.
package aes_pkg;

    localparam logic [1:0] MODE_128     = 2'b00;
    localparam logic [1:0] MODE_192     = 2'b01;
    localparam logic [1:0] MODE_256     = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    localparam int unsigned BLOCK_BYTES = 16;
    localparam int unsigned MAX_KEY_BYTES = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_KEY  = 3'd1,
        LOAD_TEXT = 3'd2,
        FULL      = 3'd3,
        ERR       = 3'd4
    } loaderState_e;

    // Number of key bytes carried in a frame for the given key-size mode.
    function automatic logic [5:0] key_bytes(input logic [1:0] mode);
        case (mode)
            MODE_192: return 6'd24;
            MODE_256: return 6'd32;
            default:  return 6'd16;
        endcase
    endfunction

endpackage

// File: rtl/aes_block_loader.sv
// Byte-serial loader: assembles key + plaintext frame into wide AES buses.
// Optional macro AES_LOADER_LASTCHK_EN enables in_last framing checks.
module aes_block_loader
    import aes_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     modeSelector,
    input  logic           in_valid,
    input  logic [7:0]     in_byte,
    input  logic           in_last,
    output logic           in_ready,
    output logic [0:255]   key_out,
    output logic [0:127]   block_out,
    output logic [1:0]     mode_out,
    output logic           out_valid,
    input  logic           out_ack,
    output logic           err
);

    loaderState_e state;
    logic [5:0]   byteCnt;

    logic         accept;
    logic [5:0]   keyLen;
    logic [5:0]   frameLast;
    logic [3:0]   textIdx;
    logic         isLast;
    logic         lastBad;

    // Frame geometry for the latched mode and in_last consistency check.
    always_comb begin
        accept    = in_valid && in_ready;
        keyLen    = key_bytes(mode_out);
        frameLast = keyLen + 6'(BLOCK_BYTES - 1);
        textIdx   = 4'(byteCnt - keyLen);
        isLast    = (state == LOAD_TEXT) && (byteCnt == frameLast);
`ifdef AES_LOADER_LASTCHK_EN
        lastBad   = (in_last != isLast);
`else
        lastBad   = in_last & 1'b0;
`endif
    end

    // Loader FSM with registered handshake outputs and byte-lane writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            byteCnt   <= 6'd0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            key_out   <= '0;
            block_out <= '0;
            mode_out  <= MODE_128;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (modeSelector == MODE_ILLEGAL || lastBad) begin
                            state    <= ERR;
                            err      <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            mode_out <= modeSelector;
                            key_out  <= {in_byte, 248'd0};
                            byteCnt  <= 6'd1;
                            state    <= LOAD_KEY;
                        end
                    end
                end

                LOAD_KEY: begin
                    if (accept) begin
                        if (lastBad) begin
                            state    <= ERR;
                            err      <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            key_out[{byteCnt[4:0], 3'b000} +: 8] <= in_byte;
                            byteCnt <= byteCnt + 6'd1;
                            if (byteCnt == keyLen - 6'd1) begin
                                state <= LOAD_TEXT;
                            end
                        end
                    end
                end

                LOAD_TEXT: begin
                    if (accept) begin
                        if (lastBad) begin
                            state    <= ERR;
                            err      <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            block_out[{textIdx, 3'b000} +: 8] <= in_byte;
                            if (isLast) begin
                                state     <= FULL;
                                in_ready  <= 1'b0;
                                out_valid <= 1'b1;
                            end else begin
                                byteCnt <= byteCnt + 6'd1;
                            end
                        end
                    end
                end

                FULL: begin
                    if (out_ack) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        byteCnt   <= 6'd0;
                    end
                end

                ERR: begin
                    err       <= 1'b1;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end

                default: begin
                    state     <= ERR;
                    err       <= 1'b1;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Scoreboard bench for aes_block_loader; honours AES_LOADER_LASTCHK_EN.
module tb_aes_block_loader;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     modeSelector;
    logic           in_valid;
    logic [7:0]     in_byte;
    logic           in_last;
    logic           in_ready;
    logic [0:255]   key_out;
    logic [0:127]   block_out;
    logic [1:0]     mode_out;
    logic           out_valid;
    logic           out_ack;
    logic           err;

    typedef struct {
        logic [255:0] key;
        logic [127:0] blk;
        logic [1:0]   mode;
        int           n;
    } expFrame_t;

    expFrame_t sb[$];
    int total = 0;
    int bad = 0;
    int accCnt = 0;
    logic prevValid = 1'b0;

    localparam logic [127:0] TEXT0 = 128'h00112233445566778899aabbccddeeff;

    aes_block_loader dut (
        .clk(clk),
        .reset(reset),
        .modeSelector(modeSelector),
        .in_valid(in_valid),
        .in_byte(in_byte),
        .in_last(in_last),
        .in_ready(in_ready),
        .key_out(key_out),
        .block_out(block_out),
        .mode_out(mode_out),
        .out_valid(out_valid),
        .out_ack(out_ack),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int keyLenOf(input logic [1:0] mode);
        return (mode == 2'b00) ? 16 : (mode == 2'b01) ? 24 : 32;
    endfunction

    function automatic logic [255:0] maskKey(input logic [255:0] key, input int k);
        logic [255:0] ones;
        ones = {256{1'b1}};
        return key & ~(ones >> (8 * k));
    endfunction

    // Output monitor: counts accepted bytes, pops the scoreboard on each out_valid rise.
    initial begin
        expFrame_t e;
        logic acc;
        logic rst;
        forever begin
            @(posedge clk);
            acc = in_valid && in_ready;
            rst = reset;
            #1;
            if (rst) accCnt = 0;
            else if (acc) accCnt++;
            if (out_valid && !prevValid) begin
                if (sb.size() == 0) begin
                    chk("spuriousValid", 256'd1, 256'd0);
                end else begin
                    e = sb.pop_front();
                    chk("frameKey", 256'(key_out), e.key);
                    chk("frameBlk", 256'(block_out), 256'(e.blk));
                    chk("frameMode", 256'(mode_out), 256'(e.mode));
                    chk("frameLen", 256'(accCnt), 256'(e.n));
                end
                accCnt = 0;
            end
            prevValid = out_valid;
        end
    end

    // Streams one frame; stops early after lastPos when the frame is expected to error.
    task automatic sendFrame(input logic [1:0] mode, input logic [255:0] key, input logic [127:0] blk,
                             input int lastPos, input bit expectOk, input bit flipMode,
                             input bit holdValid);
        int k;
        int n;
        int budget;
        expFrame_t e;
        k = keyLenOf(mode);
        n = k + 16;
        if (expectOk) begin
            e.key = maskKey(key, k);
            e.blk = blk;
            e.mode = mode;
            e.n = n;
            sb.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            modeSelector = (flipMode && i > 0) ? ~mode : mode;
            in_valid = 1'b1;
            in_byte = (i < k) ? key[255 - 8 * i -: 8] : blk[127 - 8 * (i - k) -: 8];
            in_last = (lastPos < 0) ? (i == n - 1) : (i == lastPos);
            budget = 0;
            while (!in_ready && budget < 20) begin
                step();
                budget++;
            end
            if (!in_ready) begin
                chk("readyWait", 256'd0, 256'd1);
                in_valid = 1'b0;
                return;
            end
            step();
            if (!expectOk && i == lastPos) break;
        end
        if (expectOk) chk("latency", 256'(out_valid), 256'd1);
        if (!holdValid) in_valid = 1'b0;
        in_last = 1'b0;
        modeSelector = mode;
    endtask

    task automatic doAck();
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        chk("ackValid", 256'(out_valid), 256'd0);
        chk("ackReady", 256'(in_ready), 256'd1);
    endtask

    task automatic checkResetVals(input string tag);
        chk({tag, "Valid"}, 256'(out_valid), 256'd0);
        chk({tag, "Err"}, 256'(err), 256'd0);
        chk({tag, "Key"}, 256'(key_out), 256'd0);
        chk({tag, "Blk"}, 256'(block_out), 256'd0);
        chk({tag, "Mode"}, 256'(mode_out), 256'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] key;
        logic [127:0] blk;
        logic [1:0] m;

        reset = 1'b1;
        modeSelector = 2'b00;
        in_valid = 1'b0;
        in_byte = 8'h00;
        in_last = 1'b0;
        out_ack = 1'b0;
        step();
        step();
        chk("rstReady", 256'(in_ready), 256'd0);
        checkResetVals("rst");
        reset = 1'b0;
        step();
        chk("postRstReady", 256'(in_ready), 256'd1);

        // Stray ack while idle must be ignored
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        chk("strayAckValid", 256'(out_valid), 256'd0);

        // Mode 00 with the reference key/plaintext
        key = '0;
        for (int i = 0; i < 32; i++) key[255 - 8 * i -: 8] = 8'(i);
        sendFrame(2'b00, key, TEXT0, -1, 1'b1, 1'b0, 1'b0);
        chk("m0KeyHi", 256'(key_out), {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        doAck();
        chk("holdKey", 256'(key_out), {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        chk("holdBlk", 256'(block_out), 256'(TEXT0));

        // Mode 10, then backpressure with in_valid held high
        sendFrame(2'b10, key, TEXT0, -1, 1'b1, 1'b0, 1'b1);
        in_byte = 8'h5a;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bpValid", 256'(out_valid), 256'd1);
            chk("bpReady", 256'(in_ready), 256'd0);
            chk("bpKey", 256'(key_out), key);
            chk("bpBlk", 256'(block_out), 256'(TEXT0));
        end
        in_valid = 1'b0;
        doAck();

        // Mode 01 with modeSelector disturbed mid-frame
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        blk = {$urandom, $urandom, $urandom, $urandom};
        sendFrame(2'b01, key, blk, -1, 1'b1, 1'b1, 1'b0);
        doAck();

        // Reset after 10 bytes, then a full mode-01 frame
        modeSelector = 2'b01;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_byte = 8'(8'hc0 + i);
            step();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midRstReady", 256'(in_ready), 256'd0);
        checkResetVals("midRst");
        step();
        chk("midRstReady2", 256'(in_ready), 256'd1);
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        sendFrame(2'b01, key, TEXT0, -1, 1'b1, 1'b0, 1'b0);
        doAck();

        // Random frames with random ack delay
        for (int f = 0; f < 4; f++) begin
            m = 2'($urandom_range(0, 2));
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            blk = {$urandom, $urandom, $urandom, $urandom};
            sendFrame(m, key, blk, -1, 1'b1, 1'b0, 1'b0);
            repeat ($urandom_range(0, 3)) step();
            doAck();
        end

        // in_last asserted early on byte 20
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
`ifdef AES_LOADER_LASTCHK_EN
        sendFrame(2'b00, key, TEXT0, 20, 1'b0, 1'b0, 1'b0);
        chk("lastErr", 256'(err), 256'd1);
        chk("lastValid", 256'(out_valid), 256'd0);
        chk("lastReady", 256'(in_ready), 256'd0);
        repeat (20) step();
        chk("lastNoValid", 256'(out_valid), 256'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("lastRstErr", 256'(err), 256'd0);
`else
        sendFrame(2'b00, key, TEXT0, 20, 1'b1, 1'b0, 1'b0);
        chk("lastIgnoredErr", 256'(err), 256'd0);
        doAck();
`endif

        // Illegal mode on first byte
        chk("illPreReady", 256'(in_ready), 256'd1);
        modeSelector = 2'b11;
        in_valid = 1'b1;
        in_byte = 8'haa;
        step();
        for (int c = 0; c < 4; c++) begin
            chk("illErr", 256'(err), 256'd1);
            chk("illReady", 256'(in_ready), 256'd0);
            chk("illValid", 256'(out_valid), 256'd0);
            step();
        end
        in_valid = 1'b0;
        modeSelector = 2'b00;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("illRstErr", 256'(err), 256'd0);
        chk("illRstReady", 256'(in_ready), 256'd1);

        chk("sbEmpty", 256'(sb.size()), 256'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
